conv_encoder_k3: RTL



---
 rtl/conv_encoder_k3.sv | 130 +++++++++++++
 1 files changed

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 K=3 convolutional encoder (g0=111, g1=101), bytes in MSB first.
// Define CONV_ENC_TAIL_EN to append two zero-input flush symbols per frame.
module conv_encoder_k3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] enc_bits,
  output logic       enc_valid,
  input  logic       enc_ready,
  output logic       enc_last,
  output logic       busy
);

`ifdef CONV_ENC_TAIL_EN
  localparam logic TAIL_EN = 1'b1;
`else
  localparam logic TAIL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    TAIL
  } state_t;

  state_t     fsm;
  logic [7:0] sr;
  logic [7:0] hold_data;
  logic       hold_last;
  logic       hold_full;
  logic       cur_last;
  logic       s1;
  logic       s2;
  logic [2:0] cnt;

  logic u;
  logic hs;
  logic acc;
  logic sym_last;
  logic byte_end;
  logic tail_end;
  logic go_tail;
  logic free;

  assign u        = sr[7];
  assign hs       = enc_valid && enc_ready;
  assign acc      = in_valid && in_ready;
  assign sym_last = (cnt == 3'd0);
  assign byte_end = (fsm == SHIFT) && sym_last && hs;
  assign tail_end = (fsm == TAIL) && sym_last && hs;
  assign go_tail  = byte_end && TAIL_EN && cur_last;
  assign free     = (fsm == IDLE)
                 || (byte_end && !go_tail)
                 || tail_end;

  assign in_ready  = !hold_full && rst_n;
  assign enc_valid = (fsm != IDLE);
  assign enc_bits  = enc_valid ? {u ^ s1 ^ s2, u ^ s2} : 2'b00;
  assign busy      = (fsm != IDLE) || hold_full;

`ifdef CONV_ENC_TAIL_EN
  assign enc_last = (fsm == TAIL) && sym_last;
`else
  assign enc_last = (fsm == SHIFT) && sym_last && cur_last;
`endif

  // Sequencer: shifter/hold loading, trellis state and symbol counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      sr        <= 8'h00;
      hold_data <= 8'h00;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      cur_last  <= 1'b0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= 3'd0;
    end else if (free) begin
      if (fsm == IDLE || cur_last) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= u;
        s2 <= s1;
      end
      if (hold_full) begin
        sr        <= hold_data;
        cur_last  <= hold_last;
        fsm       <= SHIFT;
        cnt       <= 3'd7;
        hold_full <= acc;
        if (acc) begin
          hold_data <= in_data;
          hold_last <= in_last;
        end
      end else if (acc) begin
        sr       <= in_data;
        cur_last <= in_last;
        fsm      <= SHIFT;
        cnt      <= 3'd7;
      end else begin
        sr       <= 8'h00;
        cur_last <= 1'b0;
        fsm      <= IDLE;
        cnt      <= 3'd0;
      end
    end else begin
      if (acc) begin
        hold_data <= in_data;
        hold_last <= in_last;
        hold_full <= 1'b1;
      end
      if (hs) begin
        sr  <= {sr[6:0], 1'b0};
        s1  <= u;
        s2  <= s1;
        cnt <= cnt - 3'd1;
        if (go_tail) begin
          fsm <= TAIL;
          cnt <= 3'd1;
        end
      end
    end
  end

endmodule
